// File: rtl/mips_debug_pkg.sv
// Shared constants, select codes and FSM encoding for the MIPS debug collector path.
package mips_debug_pkg;

    localparam int NB_FRAME        = 32;
    localparam int NB_LATCH        = 96;
    localparam int N_LATCH_GROUPS  = 8;
    localparam int NB_SELECT       = 6;
    localparam int NB_REG_ADDR     = 5;
    localparam int WORDS_PER_LATCH = NB_LATCH / NB_FRAME;
    localparam int NB_WORD_IDX     = $clog2(WORDS_PER_LATCH + 1);
    localparam int NB_GROUP_IDX    = $clog2(N_LATCH_GROUPS);

    localparam logic [NB_SELECT-1:0] REQ_SEL_MEM_DATA   = 6'b100000;
    localparam logic [NB_SELECT-1:0] REQ_SEL_MEM_INSTR  = 6'b100001;
    localparam logic [NB_SELECT-1:0] REQ_SEL_PC         = 6'b100010;
    localparam logic [NB_SELECT-1:0] REQ_SEL_LATCH_BASE = 6'b100100;
    localparam logic [NB_SELECT-1:0] REQ_SEL_LATCH_LAST = REQ_SEL_LATCH_BASE + NB_SELECT'(N_LATCH_GROUPS - 1);
    localparam logic [NB_SELECT-1:0] REQ_SEL_NONE       = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_EOD
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_REG,
        SRC_MEM_DATA,
        SRC_MEM_INSTR,
        SRC_PC,
        SRC_LATCH
    } src_t;

    typedef struct packed {
        src_t                    src;
        logic [NB_GROUP_IDX-1:0] group;
        logic [NB_WORD_IDX-1:0]  n_words;
    } req_t;

    // Unknown codes decode to SRC_NONE with zero words, which sends the FSM straight to EOD.
    function automatic req_t decode_request(input logic [NB_SELECT-1:0] sel);
        req_t r;
        r = '0;
        if (!sel[NB_SELECT-1]) begin
            r.src     = SRC_REG;
            r.n_words = NB_WORD_IDX'(1);
        end else if (sel == REQ_SEL_MEM_DATA) begin
            r.src     = SRC_MEM_DATA;
            r.n_words = NB_WORD_IDX'(1);
        end else if (sel == REQ_SEL_MEM_INSTR) begin
            r.src     = SRC_MEM_INSTR;
            r.n_words = NB_WORD_IDX'(1);
        end else if (sel == REQ_SEL_PC) begin
            r.src     = SRC_PC;
            r.n_words = NB_WORD_IDX'(1);
        end else if (sel >= REQ_SEL_LATCH_BASE && sel <= REQ_SEL_LATCH_LAST) begin
            r.src     = SRC_LATCH;
            r.group   = NB_GROUP_IDX'(sel - REQ_SEL_LATCH_BASE);
            r.n_words = NB_WORD_IDX'(WORDS_PER_LATCH);
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_debug_collector_if.sv
// Request/response bundle between the debug interface capture buffer and the collector.
interface mips_debug_collector_if;
    import mips_debug_pkg::*;

    logic [NB_SELECT-1:0] request_select;
    logic [NB_FRAME-1:0]  frame;
    logic                 eod;
    logic                 busy;

    modport master (output request_select, input frame, eod, busy);
    modport slave  (input request_select, output frame, eod, busy);

endinterface

// File: rtl/mips_debug_word_mux.sv
// Picks one NB_FRAME word (MSB word first) out of a concatenated bus of latch groups.
module mips_debug_word_mux
    import mips_debug_pkg::*;
#(
    parameter int N_GROUPS = N_LATCH_GROUPS
) (
    input  logic [N_GROUPS*NB_LATCH-1:0] i_groups,
    input  logic [NB_GROUP_IDX-1:0]      i_group_idx,
    input  logic [NB_WORD_IDX-1:0]       i_word_idx,
    output logic [NB_FRAME-1:0]          o_word
);

    always_comb begin
        o_word = '0;
        for (int g = 0; g < N_GROUPS; g++) begin
            for (int k = 0; k < WORDS_PER_LATCH; k++) begin
                if (i_group_idx == NB_GROUP_IDX'(g) && i_word_idx == NB_WORD_IDX'(k)) begin
                    o_word = i_groups[g*NB_LATCH + NB_LATCH-1 - k*NB_FRAME -: NB_FRAME];
                end
            end
        end
    end

endmodule

// File: rtl/mips_debug_collector.sv
// Turns a one-cycle debug select pulse into a frame stream plus end-of-data pulse.
// Build option MIPS_DBG_SNAPSHOT_EN streams from a shadow copy taken at request time.
module mips_debug_collector
    import mips_debug_pkg::*;
(
    input  logic                               i_clock,
    input  logic                               i_reset,
    mips_debug_collector_if.slave              dbg,
    input  logic [N_LATCH_GROUPS*NB_LATCH-1:0] i_latch_groups,
    input  logic [NB_FRAME-1:0]                i_reg_rd_data,
    input  logic [NB_FRAME-1:0]                i_pc,
    input  logic [NB_FRAME-1:0]                i_mem_data_rd_data,
    input  logic [NB_FRAME-1:0]                i_mem_instr_rd_data,
    output logic [NB_REG_ADDR-1:0]             o_reg_rd_addr,
    output logic                               o_mem_data_re,
    output logic                               o_mem_instr_re
);

    state_t                  state_q, state_d;
    req_t                    req_in, req_q;
    logic [NB_WORD_IDX-1:0]  word_idx_q;
    logic [NB_REG_ADDR-1:0]  reg_rd_addr_q;
    logic                    accept;
    logic                    last_word;
    logic [NB_GROUP_IDX-1:0] mux_group;
    logic [NB_WORD_IDX-1:0]  mux_word_idx;
    logic [NB_FRAME-1:0]     mux_word;
    logic [NB_FRAME-1:0]     rd_word;
    logic [NB_FRAME-1:0]     stream_word;

    assign req_in    = decode_request(dbg.request_select);
    assign accept    = (state_q == ST_IDLE) && (dbg.request_select != REQ_SEL_NONE);
    assign last_word = (word_idx_q == (req_q.n_words - NB_WORD_IDX'(1)));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            word_idx_q    <= '0;
            reg_rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q         <= req_in;
                word_idx_q    <= '0;
                reg_rd_addr_q <= dbg.request_select[NB_REG_ADDR-1:0];
            end else if (state_q == ST_STREAM) begin
                word_idx_q <= word_idx_q + NB_WORD_IDX'(1);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        dbg.busy       = 1'b0;
        dbg.eod        = 1'b0;
        o_mem_data_re  = 1'b0;
        o_mem_instr_re = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d        = (req_in.n_words != '0) ? ST_STREAM : ST_EOD;
                    // Memory ports have one cycle of latency, so enables fire in the select cycle.
                    o_mem_data_re  = !i_reset && (dbg.request_select == REQ_SEL_MEM_DATA);
                    o_mem_instr_re = !i_reset && (dbg.request_select == REQ_SEL_MEM_INSTR);
                end
            end
            ST_STREAM: begin
                dbg.busy = 1'b1;
                if (last_word) begin
                    state_d = ST_EOD;
                end
            end
            ST_EOD: begin
                dbg.busy = 1'b1;
                dbg.eod  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register and memory sources only become valid in the first stream cycle.
    always_comb begin
        rd_word = '0;
        case (req_q.src)
            SRC_REG:       rd_word = i_reg_rd_data;
            SRC_MEM_DATA:  rd_word = i_mem_data_rd_data;
            SRC_MEM_INSTR: rd_word = i_mem_instr_rd_data;
            default:       rd_word = '0;
        endcase
    end

`ifdef MIPS_DBG_SNAPSHOT_EN
    logic [NB_LATCH-1:0] shadow_q;

    assign mux_group    = '0;
    assign mux_word_idx = word_idx_q;

    mips_debug_word_mux #(
        .N_GROUPS    (1)
    ) u_word_mux (
        .i_groups    (shadow_q),
        .i_group_idx (mux_group),
        .i_word_idx  (mux_word_idx),
        .o_word      (mux_word)
    );

    always_ff @(posedge i_clock) begin
        if (accept) begin
            if (req_in.src == SRC_LATCH) begin
                shadow_q <= i_latch_groups[req_in.group*NB_LATCH +: NB_LATCH];
            end else begin
                shadow_q <= {{(NB_LATCH-NB_FRAME){1'b0}}, i_pc};
            end
        end else if (state_q == ST_STREAM && word_idx_q == '0 &&
                     (req_q.src == SRC_REG || req_q.src == SRC_MEM_DATA || req_q.src == SRC_MEM_INSTR)) begin
            shadow_q[NB_FRAME-1:0] <= rd_word;
        end
    end

    always_comb begin
        stream_word = rd_word;
        if (req_q.src == SRC_LATCH) begin
            stream_word = mux_word;
        end else if (req_q.src == SRC_PC) begin
            stream_word = shadow_q[NB_FRAME-1:0];
        end
    end
`else
    logic [NB_FRAME-1:0] frame_q;

    // Look one word ahead so the registered frame holds word k during stream cycle k.
    assign mux_group    = accept ? req_in.group : req_q.group;
    assign mux_word_idx = accept ? '0 : (word_idx_q + NB_WORD_IDX'(1));

    mips_debug_word_mux #(
        .N_GROUPS    (N_LATCH_GROUPS)
    ) u_word_mux (
        .i_groups    (i_latch_groups),
        .i_group_idx (mux_group),
        .i_word_idx  (mux_word_idx),
        .o_word      (mux_word)
    );

    always_ff @(posedge i_clock) begin
        if (accept) begin
            frame_q <= (req_in.src == SRC_PC) ? i_pc : mux_word;
        end else if (state_q == ST_STREAM) begin
            frame_q <= mux_word;
        end
    end

    always_comb begin
        stream_word = rd_word;
        if (req_q.src == SRC_LATCH || req_q.src == SRC_PC) begin
            stream_word = frame_q;
        end
    end
`endif

    assign dbg.frame     = (state_q == ST_STREAM) ? stream_word : '0;
    assign o_reg_rd_addr = reg_rd_addr_q;

endmodule

// File: tb/tb_mips_debug_collector.sv
// Scoreboard bench for mips_debug_collector: expected frames queued at request time, popped per busy cycle.
module tb_mips_debug_collector;
    import mips_debug_pkg::*;

    typedef struct {
        logic [31:0] frame;
        logic        eod;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [767:0] latch_bus;
    logic [31:0]  reg_rd_data;
    logic [31:0]  pc;
    logic [31:0]  mem_data_rd;
    logic [31:0]  mem_instr_rd;
    logic [4:0]   reg_rd_addr;
    logic         mem_data_re;
    logic         mem_instr_re;
    logic [31:0]  mem_data_val  = 32'hCAFE0001;
    logic [31:0]  mem_instr_val = 32'h8C220004;
    logic         started = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         sb[$];
    exp_t         mon_e;

    always #5 clk = ~clk;

    mips_debug_collector_if dbg_if ();

    mips_debug_collector dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .dbg                 (dbg_if.slave),
        .i_latch_groups      (latch_bus),
        .i_reg_rd_data       (reg_rd_data),
        .i_pc                (pc),
        .i_mem_data_rd_data  (mem_data_rd),
        .i_mem_instr_rd_data (mem_instr_rd),
        .o_reg_rd_addr       (reg_rd_addr),
        .o_mem_data_re       (mem_data_re),
        .o_mem_instr_re      (mem_instr_re)
    );

    function automatic logic [31:0] reg_model(input logic [4:0] addr);
        return (addr == 5'd5) ? 32'hDEADBEEF : {16'hA5A5, 11'h0, addr};
    endfunction

    assign reg_rd_data = reg_model(reg_rd_addr);

    // Memories answer one cycle after the enable; garbage otherwise so timing slips show up.
    always @(posedge clk) begin
        mem_data_rd  <= mem_data_re  ? mem_data_val  : 32'h0BAD0BAD;
        mem_instr_rd <= mem_instr_re ? mem_instr_val : 32'h0BAD1BAD;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_expect(input logic [5:0] sel);
        int g;
        if (sel[5] == 1'b0) begin
            sb.push_back('{frame: reg_model(sel[4:0]), eod: 1'b0});
        end else if (sel == 6'b100000) begin
            sb.push_back('{frame: mem_data_val, eod: 1'b0});
        end else if (sel == 6'b100001) begin
            sb.push_back('{frame: mem_instr_val, eod: 1'b0});
        end else if (sel == 6'b100010) begin
            sb.push_back('{frame: pc, eod: 1'b0});
        end else if (sel >= 6'd36 && sel <= 6'd43) begin
            g = int'(sel) - 36;
            for (int k = 0; k < 3; k++) begin
                sb.push_back('{frame: 32'(latch_bus >> (g*96 + (2-k)*32)), eod: 1'b0});
            end
        end
        sb.push_back('{frame: 32'h0, eod: 1'b1});
    endtask

    task automatic drive_select(input logic [5:0] sel);
        dbg_if.request_select = sel;
        #1;
        chk_eq("mem_data_re_T", {31'b0, mem_data_re}, {31'b0, sel == 6'b100000});
        chk_eq("mem_instr_re_T", {31'b0, mem_instr_re}, {31'b0, sel == 6'b100001});
        @(posedge clk);
        #1;
        dbg_if.request_select = 6'b111111;
        chk_eq("mem_re_T1", {30'b0, mem_data_re, mem_instr_re}, 32'h0);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(posedge clk);
            #2;
            done = (sb.size() == 0) && !dbg_if.busy;
        end
        chk_eq(tag, {31'b0, done}, 32'h1);
    endtask

    task automatic do_request(input logic [5:0] sel, input string tag);
        push_expect(sel);
        drive_select(sel);
        drain(tag);
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            if (dbg_if.busy) begin
                if (sb.size() == 0) begin
                    chk_eq("unexpected_busy", 32'h1, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk_eq("frame", dbg_if.frame, mon_e.frame);
                    chk_eq("eod", {31'b0, dbg_if.eod}, {31'b0, mon_e.eod});
                end
            end else begin
                chk_eq("idle_eod", {31'b0, dbg_if.eod}, 32'h0);
                chk_eq("idle_frame", dbg_if.frame, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                   = 1'b1;
        dbg_if.request_select = 6'b111111;
        pc                    = 32'h0040_0120;
        for (int g = 0; g < 8; g++) begin
            latch_bus[g*96 +: 96] = {$urandom, $urandom, $urandom};
        end
        latch_bus[95:0] = 96'h11111111_22222222_33333333;

        #1;
        chk_eq("reset_frame", dbg_if.frame, 32'h0);
        chk_eq("reset_eod", {31'b0, dbg_if.eod}, 32'h0);
        chk_eq("reset_busy", {31'b0, dbg_if.busy}, 32'h0);
        chk_eq("reset_reg_addr", {27'b0, reg_rd_addr}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;

        do_request(6'b000101, "drain_reg5");
        chk_eq("reg_addr_5", {27'b0, reg_rd_addr}, 32'd5);
        // Next request lands in the idle cycle right after EOD.
        do_request(6'b000011, "drain_reg3_b2b");
        do_request(6'b100100, "drain_latch0");
        do_request(6'b101001, "drain_latch5");
        do_request(6'b101011, "drain_latch7");
        do_request(6'b100000, "drain_mem_data");
        do_request(6'b100001, "drain_mem_instr");
        do_request(6'b100010, "drain_pc");
        do_request(6'b101100, "drain_invalid_2c");
        do_request(6'b111000, "drain_invalid_38");

        push_expect(6'b100100);
        drive_select(6'b100100);
        @(posedge clk);
        #1;
        dbg_if.request_select = 6'b000001;
        @(posedge clk);
        #1;
        dbg_if.request_select = 6'b111111;
        drain("drain_busy_ignore");
        chk_eq("reg_addr_hold", {27'b0, reg_rd_addr}, 32'd4);

        sb.push_back('{frame: 32'h11111111, eod: 1'b0});
`ifdef MIPS_DBG_SNAPSHOT_EN
        sb.push_back('{frame: 32'h22222222, eod: 1'b0});
        sb.push_back('{frame: 32'h33333333, eod: 1'b0});
`else
        sb.push_back('{frame: 32'h0, eod: 1'b0});
        sb.push_back('{frame: 32'h0, eod: 1'b0});
`endif
        sb.push_back('{frame: 32'h0, eod: 1'b1});
        drive_select(6'b100100);
        latch_bus[95:0] = 96'h0;
        drain("drain_snapshot");
        latch_bus[95:0] = 96'h11111111_22222222_33333333;

        push_expect(6'b101001);
        drive_select(6'b101001);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_eq("midrst_busy", {31'b0, dbg_if.busy}, 32'h0);
        chk_eq("midrst_eod", {31'b0, dbg_if.eod}, 32'h0);
        chk_eq("midrst_frame", dbg_if.frame, 32'h0);
        chk_eq("midrst_reg_addr", {27'b0, reg_rd_addr}, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_request(6'b000101, "drain_after_reset");
        do_request(6'b100110, "drain_latch2_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
